// File: rtl/cdb_arbiter.sv
// Common-data-bus writeback arbiter: each execute unit owns a one-entry holding
// buffer, and a round-robin pointer moves one buffered result per cycle onto a registered CDB.
module cdb_arbiter #(
  parameter int NUM_REQ       = 3,
  parameter int ROB_WIDTH_BIT = 5
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             rdy_in,
  input  logic                             clear,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*ROB_WIDTH_BIT-1:0] req_rob_id,
  input  logic [NUM_REQ*32-1:0]            req_val,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             cdb_valid,
  output logic [ROB_WIDTH_BIT-1:0]         cdb_rob_id,
  output logic [31:0]                      cdb_val,
  output logic [2:0]                       cdb_src
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  logic [NUM_REQ-1:0]       bufValid_q, bufValid_d;
  logic [ROB_WIDTH_BIT-1:0] bufId_q  [NUM_REQ];
  logic [ROB_WIDTH_BIT-1:0] bufId_d  [NUM_REQ];
  logic [31:0]              bufVal_q [NUM_REQ];
  logic [31:0]              bufVal_d [NUM_REQ];
  logic [PTR_W-1:0]         ptr_q, ptr_d;

  logic                     cdbValid_q, cdbValid_d;
  logic [ROB_WIDTH_BIT-1:0] cdbRobId_q, cdbRobId_d;
  logic [31:0]              cdbVal_q, cdbVal_d;
  logic [2:0]               cdbSrc_q, cdbSrc_d;

  logic [NUM_REQ-1:0]       grant;
  logic [PTR_W-1:0]         grantIdx;
  logic                     grantFound;

  function automatic logic [PTR_W-1:0] wrapIdx(input logic [PTR_W-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return PTR_W'(sum);
  endfunction

  // Grant looks only at buffered state, so req_ready never depends on req_valid.
  always_comb begin
    grant      = '0;
    grantIdx   = '0;
    grantFound = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grantFound && bufValid_q[wrapIdx(ptr_q, k)]) begin
        grantFound = 1'b1;
        grantIdx   = wrapIdx(ptr_q, k);
      end
    end
    if (grantFound) grant[grantIdx] = 1'b1;
  end

  // A granted buffer reopens in the same cycle, so one unit can stream every cycle.
  assign req_ready = (rst_in && rdy_in && !clear) ? (~bufValid_q | grant) : '0;

  always_comb begin
    bufValid_d = bufValid_q;
    bufId_d    = bufId_q;
    bufVal_d   = bufVal_q;
    ptr_d      = ptr_q;
    cdbValid_d = cdbValid_q;
    cdbRobId_d = cdbRobId_q;
    cdbVal_d   = cdbVal_q;
    cdbSrc_d   = cdbSrc_q;
    if (rdy_in) begin
      if (clear) begin
        bufValid_d = '0;
        cdbValid_d = 1'b0;
        ptr_d      = '0;
      end else begin
        cdbValid_d = grantFound;
        if (grantFound) begin
          cdbRobId_d           = bufId_q[grantIdx];
          cdbVal_d             = bufVal_q[grantIdx];
          cdbSrc_d             = 3'(grantIdx);
          bufValid_d[grantIdx] = 1'b0;
          ptr_d                = (grantIdx == LAST_IDX) ? '0 : grantIdx + 1'b1;
        end
        // Loading after the grant-clear lets a refill win on the granted index.
        for (int i = 0; i < NUM_REQ; i++) begin
          if (req_valid[i] && req_ready[i]) begin
            bufValid_d[i] = 1'b1;
            bufId_d[i]    = req_rob_id[i*ROB_WIDTH_BIT +: ROB_WIDTH_BIT];
            bufVal_d[i]   = req_val[i*32 +: 32];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      bufValid_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        bufId_q[i]  <= '0;
        bufVal_q[i] <= '0;
      end
      ptr_q      <= '0;
      cdbValid_q <= 1'b0;
      cdbRobId_q <= '0;
      cdbVal_q   <= '0;
      cdbSrc_q   <= '0;
    end else begin
      bufValid_q <= bufValid_d;
      bufId_q    <= bufId_d;
      bufVal_q   <= bufVal_d;
      ptr_q      <= ptr_d;
      cdbValid_q <= cdbValid_d;
      cdbRobId_q <= cdbRobId_d;
      cdbVal_q   <= cdbVal_d;
      cdbSrc_q   <= cdbSrc_d;
    end
  end

  assign cdb_valid  = cdbValid_q;
  assign cdb_rob_id = cdbRobId_q;
  assign cdb_val    = cdbVal_q;
  assign cdb_src    = cdbSrc_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a slot-level reference model.
module tb_cdb_arbiter;

  localparam int N  = 3;
  localparam int RW = 5;

  logic            clk_in     = 1'b0;
  logic            rst_in     = 1'b1;
  logic            rdy_in     = 1'b0;
  logic            clear      = 1'b0;
  logic [N-1:0]    req_valid  = '0;
  logic [N*RW-1:0] req_rob_id = '0;
  logic [N*32-1:0] req_val    = '0;
  logic [N-1:0]    req_ready;
  logic            cdb_valid;
  logic [RW-1:0]   cdb_rob_id;
  logic [31:0]     cdb_val;
  logic [2:0]      cdb_src;

  cdb_arbiter #(.NUM_REQ(N), .ROB_WIDTH_BIT(RW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .req_valid(req_valid), .req_rob_id(req_rob_id), .req_val(req_val),
    .req_ready(req_ready), .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id),
    .cdb_val(cdb_val), .cdb_src(cdb_src)
  );

  always #5 clk_in = ~clk_in;

  int testsRun  = 0;
  int failCount = 0;

  // Reference model: one slot per unit plus the rotation point and the broadcast registers.
  bit          mValid [N] = '{default: 1'b0};
  logic [RW-1:0] mId  [N] = '{default: '0};
  logic [31:0] mVal   [N] = '{default: '0};
  bit          mAcc   [N] = '{default: 1'b0};
  int          mPtr     = 0;
  bit          mCdbV    = 1'b0;
  logic [RW-1:0] mCdbId = '0;
  logic [31:0] mCdbVal  = '0;
  int          mCdbSrc  = 0;

  typedef struct {
    logic [2:0]    src;
    logic [RW-1:0] id;
    logic [31:0]   val;
  } cdbRec_t;
  cdbRec_t seenQ[$];

  task automatic checkLit(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: actual %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int findGrant();
    for (int k = 0; k < N; k++)
      if (mValid[(mPtr + k) % N]) return (mPtr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] expReady();
    logic [N-1:0] r;
    int g;
    g = findGrant();
    for (int i = 0; i < N; i++)
      r[i] = rst_in && rdy_in && !clear && (!mValid[i] || g == i);
    return r;
  endfunction

  // Advance the model at each edge, or wipe it when reset is asserted.
  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < N; i++) begin
        mValid[i] = 1'b0;
        mAcc[i]   = 1'b0;
      end
      mPtr = 0; mCdbV = 1'b0; mCdbId = '0; mCdbVal = '0; mCdbSrc = 0;
    end else begin
      logic [N-1:0] rdyV;
      int g;
      rdyV = expReady();
      g    = findGrant();
      for (int i = 0; i < N; i++) mAcc[i] = 1'b0;
      if (rdy_in) begin
        if (clear) begin
          for (int i = 0; i < N; i++) mValid[i] = 1'b0;
          mCdbV = 1'b0;
          mPtr  = 0;
        end else begin
          if (g >= 0) begin
            mCdbV = 1'b1; mCdbId = mId[g]; mCdbVal = mVal[g]; mCdbSrc = g;
            mValid[g] = 1'b0;
            mPtr = (g + 1) % N;
          end else begin
            mCdbV = 1'b0;
          end
          for (int i = 0; i < N; i++) begin
            if (req_valid[i] && rdyV[i]) begin
              mValid[i] = 1'b1;
              mId[i]    = req_rob_id[i*RW +: RW];
              mVal[i]   = req_val[i*32 +: 32];
              mAcc[i]   = 1'b1;
            end
          end
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model, away from the active edge.
  always @(negedge clk_in) begin
    checkLit("req_ready", 64'(req_ready), 64'(expReady()));
    checkLit("cdb_valid", 64'(cdb_valid), 64'(mCdbV));
    checkLit("cdb_rob_id", 64'(cdb_rob_id), 64'(mCdbId));
    checkLit("cdb_val", 64'(cdb_val), 64'(mCdbVal));
    checkLit("cdb_src", 64'(cdb_src), 64'(mCdbSrc));
  end

  // Record each broadcast once, at the cycle in which it is consumed.
  always @(negedge clk_in) begin
    if (rst_in && rdy_in && cdb_valid)
      seenQ.push_back('{src: cdb_src, id: cdb_rob_id, val: cdb_val});
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic setReq(input int u, input bit v, input int id, input logic [31:0] val);
    req_valid[u]          = v;
    req_rob_id[u*RW +: RW] = RW'(id);
    req_val[u*32 +: 32]    = val;
  endtask

  task automatic applyStimulus();
    int c0, c2;
    // Reset and idle
    #1 rst_in = 1'b0;
    rdy_in = 1'b1;
    #2;
    checkLit("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    checkLit("rst_cdb_rob_id", 64'(cdb_rob_id), 64'd0);
    checkLit("rst_cdb_val", 64'(cdb_val), 64'd0);
    checkLit("rst_cdb_src", 64'(cdb_src), 64'd0);
    checkLit("rst_req_ready", 64'(req_ready), 64'd0);
    repeat (2) tick();
    rst_in = 1'b1;
    repeat (3) tick();
    @(negedge clk_in);
    checkLit("idle_cdb_valid", 64'(cdb_valid), 64'd0);
    checkLit("idle_req_ready", 64'(req_ready), 64'b111);

    // Single unit streaming ids 4,5,6
    tick();
    seenQ.delete();
    for (int k = 0; k < 3; k++) begin
      setReq(1, 1'b1, 4 + k, 32'h40 + k);
      @(negedge clk_in);
      checkLit("stream_ready1", 64'(req_ready[1]), 64'd1);
      tick();
    end
    setReq(1, 1'b0, 0, 0);
    repeat (4) tick();
    checkLit("stream_count", 64'(seenQ.size()), 64'd3);
    for (int k = 0; k < seenQ.size() && k < 3; k++) begin
      checkLit("stream_id", 64'(seenQ[k].id), 64'(4 + k));
      checkLit("stream_src", 64'(seenQ[k].src), 64'd1);
    end

    // Clear to return the pointer to 0, then three-way contention
    clear = 1'b1;
    tick();
    clear = 1'b0;
    seenQ.delete();
    for (int u = 0; u < 3; u++) setReq(u, 1'b1, u + 1, 32'hA + u);
    tick();
    for (int u = 0; u < 3; u++) setReq(u, 1'b0, 0, 0);
    repeat (4) tick();
    checkLit("three_count", 64'(seenQ.size()), 64'd3);
    for (int k = 0; k < seenQ.size() && k < 3; k++) begin
      checkLit("three_src", 64'(seenQ[k].src), 64'(k));
      checkLit("three_id", 64'(seenQ[k].id), 64'(k + 1));
      checkLit("three_val", 64'(seenQ[k].val), 64'(32'hA + k));
    end

    // Units 0 and 2 request continuously: grants must alternate starting at 0
    seenQ.delete();
    c0 = 10; c2 = 20;
    setReq(0, 1'b1, c0, 32'h100 + c0);
    setReq(2, 1'b1, c2, 32'h200 + c2);
    for (int k = 0; k < 12; k++) begin
      tick();
      if (mAcc[0]) begin c0++; setReq(0, 1'b1, c0, 32'h100 + c0); end
      if (mAcc[2]) begin c2++; setReq(2, 1'b1, c2, 32'h200 + c2); end
    end
    setReq(0, 1'b0, 0, 0);
    setReq(2, 1'b0, 0, 0);
    repeat (4) tick();
    checkLit("rr_enough", 64'(seenQ.size() >= 8), 64'd1);
    for (int k = 0; k < seenQ.size() && k < 8; k++)
      checkLit("rr_src", 64'(seenQ[k].src), (k % 2 == 0) ? 64'd0 : 64'd2);

    // Stall with a buffered result, then flush it with clear
    seenQ.delete();
    setReq(2, 1'b1, 9, 32'h99);
    tick();
    setReq(2, 1'b0, 0, 0);
    rdy_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      checkLit("stall_ready", 64'(req_ready), 64'd0);
      checkLit("stall_cdb_valid", 64'(cdb_valid), 64'd0);
      tick();
    end
    rdy_in = 1'b1;
    clear  = 1'b1;
    tick();
    clear = 1'b0;
    @(negedge clk_in);
    checkLit("clear_cdb_valid", 64'(cdb_valid), 64'd0);
    checkLit("clear_ready", 64'(req_ready), 64'b111);
    repeat (3) tick();
    checkLit("clear_no_bcast", 64'(seenQ.size()), 64'd0);

    // Asynchronous reset while two buffers are full
    setReq(0, 1'b1, 3, 32'h33);
    setReq(1, 1'b1, 7, 32'h77);
    tick();
    tick();
    setReq(0, 1'b0, 0, 0);
    setReq(1, 1'b0, 0, 0);
    seenQ.delete();
    #2 rst_in = 1'b0;
    #1;
    checkLit("arst_cdb_valid", 64'(cdb_valid), 64'd0);
    checkLit("arst_cdb_rob_id", 64'(cdb_rob_id), 64'd0);
    checkLit("arst_cdb_val", 64'(cdb_val), 64'd0);
    checkLit("arst_cdb_src", 64'(cdb_src), 64'd0);
    checkLit("arst_ready", 64'(req_ready), 64'd0);
    tick();
    rst_in = 1'b1;
    repeat (4) tick();
    checkLit("arst_no_stale", 64'(seenQ.size()), 64'd0);

    // Randomized traffic; units hold their result until it is accepted
    for (int c = 0; c < 3000; c++) begin
      tick();
      rdy_in = ($urandom_range(9) != 0);
      clear  = ($urandom_range(39) == 0);
      for (int u = 0; u < N; u++) begin
        if (!(req_valid[u] && !mAcc[u]))
          setReq(u, ($urandom_range(9) < 6), int'($urandom_range(31)), $urandom);
      end
      if ($urandom_range(299) == 0) begin
        #1 rst_in = 1'b0;
        #2 rst_in = 1'b1;
      end
    end
    req_valid = '0;
    rdy_in    = 1'b1;
    clear     = 1'b0;
    repeat (5) tick();
  endtask

  task automatic checkOutput();
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
  endtask

  initial begin
    applyStimulus();
    checkOutput();
    $finish;
  end

endmodule
